// File: rtl/shader_pkg.sv
// Shared types and helpers for the fragment attribute interpolator.
// No logic of its own; pure declarations.
// No flow control; consumers handle backpressure.
`timescale 1ns/1ps
package shader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Fixed-point 1.0 for a gradient with frac_w fraction bits.
    function automatic logic [31:0] grad_one(input int frac_w);
        return 32'd1 << frac_w;
    endfunction

endpackage

// File: rtl/interp_lane.sv
// One interpolation lane: val = min + (max-min)*g, quotient rounded toward zero.
// Purely combinational, zero cycles.
// No flow control; operands are held stable by the caller.
`timescale 1ns/1ps
module interp_lane
    import shader_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 14
) (
    input  logic [DATA_W-1:0] min_i,
    input  logic [DATA_W-1:0] max_i,
    input  logic [DATA_W-1:0] g_i,      // already clamped to [0, 1.0]
    output logic [DATA_W-1:0] val_o
);
    localparam int PW = DATA_W + FRAC_W + 2;

    logic signed [DATA_W:0] diff;
    logic signed [PW-1:0]   diff_x;
    logic signed [PW-1:0]   g_x;
    logic signed [PW-1:0]   prod;
    logic        [PW-1:0]   mag;
    logic        [DATA_W-1:0] q_mag;
    logic        [DATA_W-1:0] q;

    // Difference needs one extra bit; the product is formed at full width so nothing wraps.
    // Dividing the magnitude rather than the signed value gives round-toward-zero,
    // which keeps the result inside [min,max] and makes g=1.0 land exactly on max.
    always_comb begin
        diff   = {max_i[DATA_W-1], max_i} - {min_i[DATA_W-1], min_i};
        diff_x = {{(PW-DATA_W-1){diff[DATA_W]}}, diff};
        g_x    = {{(PW-DATA_W){g_i[DATA_W-1]}}, g_i};
        prod   = diff_x * g_x;
        mag    = prod[PW-1] ? -prod : prod;
        q_mag  = mag[FRAC_W +: DATA_W];
        q      = prod[PW-1] ? -q_mag : q_mag;
        val_o  = min_i + q;
    end

endmodule

// File: rtl/interp_multi.sv
// Interpolates NUM_CH attributes of one fragment through a single shared lane.
// Latency: result valid NUM_CH cycles after accept; one transaction per NUM_CH+2 cycles.
// Backpressure: input ready only when idle; result held stable until out_ready.
`timescale 1ns/1ps
module interp_multi
    import shader_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 14,
    parameter int NUM_CH = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] min_val,
    input  logic [NUM_CH*DATA_W-1:0] max_val,
    input  logic [DATA_W-1:0]        gradient,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] val
);
    localparam int            CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);
    localparam int            VW      = NUM_CH * DATA_W;

    state_t              state_q, state_d;
    logic [CW-1:0]       ch_cnt_q, ch_cnt_d;
    logic [VW-1:0]       min_q, min_d;
    logic [VW-1:0]       max_q, max_d;
    logic [VW-1:0]       val_q, val_d;
    logic [DATA_W-1:0]   g_q, g_d;
    logic [DATA_W-1:0]   g_clamped;
    logic [DATA_W-1:0]   lane_val;

    // Clamp the incoming gradient to [0, 1.0] before it is captured.
    always_comb begin
        g_clamped = gradient;
        if (gradient[DATA_W-1]) begin
            g_clamped = '0;
        end else if ({{(32-DATA_W){1'b0}}, gradient} >= grad_one(FRAC_W)) begin
            g_clamped = DATA_W'(grad_one(FRAC_W));
        end
    end

    interp_lane #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_lane (
        .min_i (min_q[ch_cnt_q*DATA_W +: DATA_W]),
        .max_i (max_q[ch_cnt_q*DATA_W +: DATA_W]),
        .g_i   (g_q),
        .val_o (lane_val)
    );

    // Next state: capture in IDLE, one channel per cycle in CALC, hold in DONE until taken.
    always_comb begin
        state_d  = state_q;
        ch_cnt_d = ch_cnt_q;
        min_d    = min_q;
        max_d    = max_q;
        g_d      = g_q;
        val_d    = val_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    min_d    = min_val;
                    max_d    = max_val;
                    g_d      = g_clamped;
                    ch_cnt_d = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                val_d[ch_cnt_q*DATA_W +: DATA_W] = lane_val;
                if (ch_cnt_q == LAST_CH) begin
                    ch_cnt_d = '0;
                    state_d  = DONE;
                end else begin
                    ch_cnt_d = ch_cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any transaction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ch_cnt_q <= '0;
            min_q    <= '0;
            max_q    <= '0;
            g_q      <= '0;
            val_q    <= '0;
        end else begin
            state_q  <= state_d;
            ch_cnt_q <= ch_cnt_d;
            min_q    <= min_d;
            max_q    <= max_d;
            g_q      <= g_d;
            val_q    <= val_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign val       = val_q;

endmodule
